// File: rtl/iter_alu.sv
// Execute-stage ALU with RV32I integer ops plus RV32M multiply/divide.
// Multiply and divide iterate one bit per cycle behind a valid/ready handshake.
module iter_alu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic [4:0]          op_q, op_d;
  logic [XLEN-1:0]     ma_q, ma_d;
  logic [XLEN-1:0]     mb_q, mb_d;
  logic                an_q, an_d;
  logic                bn_q, bn_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                a_sgn, b_sgn, div_zero, div_ovf;
  logic [XLEN-1:0]     special;
  logic [2*XLEN-1:0]   mul_nxt, prod;
  logic [XLEN:0]       div_shift, div_sub;
  logic                div_ge;
  logic [2*XLEN-1:0]   div_nxt;
  logic [XLEN-1:0]     quo, rem;

  function automatic logic [XLEN-1:0] alu_single(input logic [4:0] f,
                                                 input logic [XLEN-1:0] x,
                                                 input logic [XLEN-1:0] y);
    logic signed [XLEN-1:0] xs;
    logic signed [XLEN-1:0] ys;
    logic [SHW-1:0]         sh;
    xs = x;
    ys = y;
    sh = y[SHW-1:0];
    case (f)
      OP_ADD:  alu_single = x + y;
      OP_SUB:  alu_single = x - y;
      OP_SLL:  alu_single = x << sh;
      OP_SLT:  alu_single = {{(XLEN-1){1'b0}}, xs < ys};
      OP_SLTU: alu_single = {{(XLEN-1){1'b0}}, x < y};
      OP_XOR:  alu_single = x ^ y;
      OP_SRL:  alu_single = x >> sh;
      OP_SRA:  alu_single = xs >>> sh;
      OP_OR:   alu_single = x | y;
      OP_AND:  alu_single = x & y;
      default: alu_single = '0;
    endcase
  endfunction

  function automatic logic is_mul(input logic [4:0] f);
    is_mul = (f >= OP_MUL) && (f <= OP_MULHU);
  endfunction

  function automatic logic is_div(input logic [4:0] f);
    is_div = (f >= OP_DIV) && (f <= OP_REMU);
  endfunction

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    an_d     = an_q;
    bn_d     = bn_q;
    acc_d    = acc_q;
    result_d = result_q;

    a_sgn    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_sgn    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    div_zero = (b == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
    if (div_zero)
      special = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : a;
    else
      special = (op == OP_DIV) ? a : '0;

    // Multiply: MSB-first shift-add, so the counter doubles as the multiplier bit index
    mul_nxt = {acc_q[2*XLEN-2:0], 1'b0} + (mb_q[cnt_q] ? {{XLEN{1'b0}}, ma_q} : '0);
    prod    = (an_q ^ bn_q) ? -mul_nxt : mul_nxt;

    // Divide: acc holds {partial remainder, quotient bits shifted in LSB-first}
    div_shift = {acc_q[2*XLEN-1:XLEN], ma_q[cnt_q]};
    div_ge    = (div_shift >= {1'b0, mb_q});
    div_sub   = div_shift - {1'b0, mb_q};
    div_nxt   = {(div_ge ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    quo       = (an_q ^ bn_q) ? -div_nxt[XLEN-1:0] : div_nxt[XLEN-1:0];
    rem       = an_q ? -div_nxt[2*XLEN-1:XLEN] : div_nxt[2*XLEN-1:XLEN];

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d  = op;
          an_d  = a_sgn && a[XLEN-1];
          bn_d  = b_sgn && b[XLEN-1];
          ma_d  = (a_sgn && a[XLEN-1]) ? -a : a;
          mb_d  = (b_sgn && b[XLEN-1]) ? -b : b;
          cnt_d = SHW'(XLEN-1);
          acc_d = '0;
          if (is_mul(op)) begin
            state_d = ST_MUL;
          end else if (is_div(op)) begin
            if (div_zero || div_ovf) begin
              result_d = special;
              state_d  = ST_DONE;
            end else begin
              state_d  = ST_DIV;
            end
          end else begin
            result_d = alu_single(op, a, b);
            state_d  = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        acc_d = mul_nxt;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_d = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          state_d  = ST_DONE;
        end
      end
      ST_DIV: begin
        acc_d = div_nxt;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_d = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? quo : rem;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Operand/accumulator datapath needs no reset: nothing reads it outside MUL/DIV
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    ma_q  <= ma_d;
    mb_q  <= mb_d;
    an_q  <= an_d;
    bn_q  <= bn_d;
    acc_q <= acc_d;
  end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, multi-cycle successor to the execute-stage ALU.
- Adds the RV32M multiply/divide ops alongside the RV32I integer ops, and fixes SRA to shift by the full shift amount.
- Uses a valid/ready handshake on both sides so the pipeline can stall on long operations.
- Sits in the execute stage between operand forwarding and writeback.

Parameters:
- XLEN, 32, operand/result width; must be ≥8 and a power of two.
- SHW, $clog2(XLEN), shift-amount width; only b[SHW-1:0] is used for shifts.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request presents op/a/b.
- in_ready  out  1  block can accept a request.
- op  in  5  operation code (see Behaviour).
- a  in  XLEN  operand A.
- b  in  XLEN  operand B.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  operation result.

Behaviour:
- Op codes:
  - Single-cycle group: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - Multiply group: 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU.
  - Divide group: 14 DIV, 15 DIVU, 16 REM, 17 REMU.
  - Codes 18–31: result 0, timed as single-cycle.
- Handshake: a request is accepted when in_valid && in_ready. op/a/b are captured at acceptance and ignored afterwards.
- FSM states IDLE, MUL, DIV, DONE.
  - in_ready = 1 only in IDLE.
  - out_valid = 1 only in DONE.
- IDLE:
  - On accepting a single-cycle op, compute and register the result, then go to DONE. out_valid rises the next cycle (latency 1).
  - On accepting a multiply op, go to MUL.
  - On accepting a divide op with b==0 or signed overflow, load the special result, then go to DONE (latency 1).
  - On accepting any other divide op, go to DIV.
- MUL:
  - Radix-2 shift-add over XLEN iterations on 2·XLEN-bit magnitudes, using a counter from XLEN-1 down to 0.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
  - Operands are converted to magnitudes per signedness (MULH: both signed; MULHSU: a signed, b unsigned). The product is negated at completion if the signs differ.
  - Then go to DONE. Total latency from acceptance to out_valid = XLEN+1 cycles.
- DIV:
  - Restoring division over XLEN iterations on magnitudes.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
  - Same latency as MUL: XLEN+1 cycles.
- Special divide cases:
  - b==0: DIV/DIVU return all-ones; REM/REMU return a.
  - Signed overflow (DIV/REM with a = 1 followed by XLEN-1 zeros, i.e. the most negative value, and b = -1): DIV returns a; REM returns 0.
- DONE:
  - result is held stable.
  - If out_ready is high, go to IDLE next cycle. Any in_valid seen in DONE is not accepted.
- Single-cycle arithmetic:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT is signed and SLTU is unsigned; both produce 0 or 1, zero-extended.
  - SLL/SRL/SRA shift by b[SHW-1:0]. SRA sign-fills.
- Reset (any state, including mid-iteration):
  - Next state is IDLE, the iteration counter is cleared, and in-flight work is discarded.
  - After reset: in_ready=1, out_valid=0, result=0.
- A new request cannot be accepted until the previous result has been consumed, so there is at most one operation in flight.

Test Plan:
- Single-cycle ops: ADD a=0xFFFFFFFF, b=1 → result 0, out_valid exactly 1 cycle after acceptance. SUB 5−7 → 0xFFFFFFFE. SLT 0xFFFFFFFF<1 → 1. SLTU 0xFFFFFFFF<1 → 0.
- Shifts: SRA a=0x80000000, b=0x24 (shamt 4) → 0xF8000000. SRL with the same operands → 0x08000000. SLL a=1, b=31 → 0x80000000.
- Multiply: MUL 0xFFFFFFFF×0xFFFFFFFF → 1. MULH → 0. MULHU → 0xFFFFFFFE. MULHSU a=−1, b=2 → 0xFFFFFFFF. Each must raise out_valid exactly 33 cycles after acceptance, and in_ready must stay low throughout.
- Divide: DIV −7/2 → 0xFFFFFFFD (−3). REM −7/2 → 0xFFFFFFFF (−1). DIVU 100/7 → 14. REMU 100/7 → 2. Latency 33 cycles.
- Divide special cases: DIV x/0 → 0xFFFFFFFF. REMU 9/0 → 9. DIV 0x80000000/−1 → 0x80000000. REM 0x80000000/−1 → 0. All with latency 1.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles after a result: result stays stable, out_valid stays 1, and in_valid is ignored.
  - Assert rst at iteration 12 of a DIV: the next cycle in_ready=1, out_valid=0, result=0.
  - A following ADD 2+3 → 5.
